// File: rtl/akarin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : akarin_pkg
// Brief    : Shared register-file types and constants for the write-back path.
// Revision : 1.0  initial release
// ============================================================================
package akarin_pkg;

    typedef logic [4:0]  regnum_t;
    typedef logic [31:0] word_t;

    // Arbitration priority; LSU_PRI is the reset/default state.
    typedef enum logic [0:0] {
        LSU_PRI = 1'b0,
        ALU_PRI = 1'b1
    } wb_pri_e;

    localparam regnum_t REG_ZERO = 5'd0;

    // x0 is hard-wired to zero, so writes to it are accepted but never committed.
    function automatic logic is_live_write(input regnum_t rd);
        return rd != REG_ZERO;
    endfunction

endpackage : akarin_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module   : wb_grant
// Brief    : Combinational two-way grant for the register-file write port.
// Revision : 1.0  initial release
// ============================================================================
module wb_grant
    import akarin_pkg::*;
(
    input  logic    i_alu_valid,
    input  logic    i_lsu_valid,
    input  wb_pri_e i_pri,
    output logic    o_alu_ready,
    output logic    o_lsu_ready,
    output logic    o_sel_alu
);

    logic w_sel_alu;

    // ALU wins when alone, or when contested while it holds priority.
    assign w_sel_alu   = i_alu_valid & (~i_lsu_valid | (i_pri == ALU_PRI));

    assign o_sel_alu   = w_sel_alu;
    assign o_alu_ready = w_sel_alu;
    assign o_lsu_ready = i_lsu_valid & ~w_sel_alu;

endmodule : wb_grant
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : ALU/LSU write-back arbiter with ALU starvation guard.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
    import akarin_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        aluValid_i,
    input  logic [4:0]  aluRd_i,
    input  logic [31:0] aluVal_i,
    output logic        aluReady_o,

    input  logic        lsuValid_i,
    input  logic [4:0]  lsuRd_i,
    input  logic [31:0] lsuVal_i,
    output logic        lsuReady_o,

    output logic        regWrite_o,
    output logic [4:0]  rdNum_o,
    output logic [31:0] rdVal_o,
    output logic        aluStarved_o
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    wb_pri_e          r_pri;
    wb_pri_e          w_pri_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;

    logic    r_reg_write;
    regnum_t r_rd_num;
    word_t   r_rd_val;

    logic    w_alu_ready;
    logic    w_lsu_ready;
    logic    w_sel_alu;
    logic    w_contested;
    logic    w_xfer;
    regnum_t w_win_rd;
    word_t   w_win_val;

    wb_grant u_grant (
        .i_alu_valid (aluValid_i),
        .i_lsu_valid (lsuValid_i),
        .i_pri       (r_pri),
        .o_alu_ready (w_alu_ready),
        .o_lsu_ready (w_lsu_ready),
        .o_sel_alu   (w_sel_alu)
    );

    assign w_contested = aluValid_i & lsuValid_i;
    assign w_xfer      = w_alu_ready | w_lsu_ready;
    assign w_win_rd    = w_sel_alu ? aluRd_i  : lsuRd_i;
    assign w_win_val   = w_sel_alu ? aluVal_i : lsuVal_i;

    // Priority flips as soon as the count reaches the limit, so the very
    // next contested cycle is the forced ALU win.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        w_pri_nxt      = r_pri;
        if (w_alu_ready) begin
            w_wait_cnt_nxt = '0;
            w_pri_nxt      = LSU_PRI;
        end else begin
            if (w_contested && (r_wait_cnt != c_LIMIT)) begin
                w_wait_cnt_nxt = r_wait_cnt + c_ONE;
            end
            if ((r_pri == LSU_PRI) && (w_wait_cnt_nxt == c_LIMIT)) begin
                w_pri_nxt = ALU_PRI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pri       <= LSU_PRI;
            r_wait_cnt  <= '0;
            r_reg_write <= 1'b0;
            r_rd_num    <= REG_ZERO;
            r_rd_val    <= '0;
        end else begin
            r_pri       <= w_pri_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_reg_write <= w_xfer & is_live_write(w_win_rd);
            if (w_xfer) begin
                r_rd_num <= w_win_rd;
                r_rd_val <= w_win_val;
            end
        end
    end

    assign aluReady_o   = w_alu_ready;
    assign lsuReady_o   = w_lsu_ready;
    assign regWrite_o   = r_reg_write;
    assign rdNum_o      = r_rd_num;
    assign rdVal_o      = r_rd_val;
    assign aluStarved_o = (r_pri == ALU_PRI);

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Scoreboard bench for regfile_wb_arbiter (STARVE_LIMIT = 3).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int c_LIMIT = 3;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        starved;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        aluValid_i;
    logic [4:0]  aluRd_i;
    logic [31:0] aluVal_i;
    logic        aluReady_o;
    logic        lsuValid_i;
    logic [4:0]  lsuRd_i;
    logic [31:0] lsuVal_i;
    logic        lsuReady_o;
    logic        regWrite_o;
    logic [4:0]  rdNum_o;
    logic [31:0] rdVal_o;
    logic        aluStarved_o;

    int n_cmp = 0;
    int n_err = 0;

    exp_t        sb_q[$];
    logic        m_alu_pri;
    int          m_cnt;
    logic [4:0]  m_rd;
    logic [31:0] m_val;

    regfile_wb_arbiter #(.STARVE_LIMIT(c_LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluValid_i   (aluValid_i),
        .aluRd_i      (aluRd_i),
        .aluVal_i     (aluVal_i),
        .aluReady_o   (aluReady_o),
        .lsuValid_i   (lsuValid_i),
        .lsuRd_i      (lsuRd_i),
        .lsuVal_i     (lsuVal_i),
        .lsuReady_o   (lsuReady_o),
        .regWrite_o   (regWrite_o),
        .rdNum_o      (rdNum_o),
        .rdVal_o      (rdVal_o),
        .aluStarved_o (aluStarved_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock of stimulus: drive, compare at negedge, update the reference model.
    task automatic step(input logic r,
                        input logic av, input logic [4:0] ard, input logic [31:0] aval,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
                        output logic ea, output logic el);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        aluValid_i = av; aluRd_i = ard; aluVal_i = aval;
        lsuValid_i = lv; lsuRd_i = lrd; lsuVal_i = lval;
        @(negedge clk);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("reg_write", {31'd0, regWrite_o}, {31'd0, e.we});
            check_eq("rd_num", {27'd0, rdNum_o}, {27'd0, e.rd});
            check_eq("rd_val", rdVal_o, e.val);
            check_eq("alu_starved", {31'd0, aluStarved_o}, {31'd0, e.starved});
        end
        ea = av & (~lv | m_alu_pri);
        el = lv & ~ea;
        check_eq("alu_ready", {31'd0, aluReady_o}, {31'd0, ea});
        check_eq("lsu_ready", {31'd0, lsuReady_o}, {31'd0, el});
        if (r) begin
            m_alu_pri = 1'b0; m_cnt = 0; m_rd = 5'd0; m_val = 32'd0;
            e = '{we: 1'b0, rd: 5'd0, val: 32'd0, starved: 1'b0};
        end else begin
            if (ea) begin
                m_rd = ard; m_val = aval; m_cnt = 0; m_alu_pri = 1'b0;
            end else begin
                if (el) begin
                    m_rd = lrd; m_val = lval;
                end
                if (av && lv && m_cnt < c_LIMIT) m_cnt++;
                if (m_cnt == c_LIMIT) m_alu_pri = 1'b1;
            end
            e.we      = (ea | el) && (((ea ? ard : lrd)) != 5'd0);
            e.rd      = m_rd;
            e.val     = m_val;
            e.starved = m_alu_pri;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(output logic ea, output logic el);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ea, el);
    endtask

    initial begin
        logic        ga, gl;
        logic [7:0]  pat;
        logic        pa, pl;
        logic [4:0]  rrd_a, rrd_l;
        logic [31:0] rv_a, rv_l;

        rst = 1'b1;
        aluValid_i = 1'b0; aluRd_i = '0; aluVal_i = '0;
        lsuValid_i = 1'b0; lsuRd_i = '0; lsuVal_i = '0;
        m_alu_pri = 1'b0; m_cnt = 0; m_rd = '0; m_val = '0;

        // Reset, then idle
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gl);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ga, gl);
        idle(ga, gl);
        check_eq("reset_we", {31'd0, regWrite_o}, 32'd0);
        check_eq("reset_rd", {27'd0, rdNum_o}, 32'd0);
        check_eq("reset_val", rdVal_o, 32'd0);
        check_eq("idle_ready", {30'd0, aluReady_o, lsuReady_o}, 32'd0);

        // Single ALU write
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ga, gl);
        idle(ga, gl);
        check_eq("alu_one_we", {31'd0, regWrite_o}, 32'd1);
        check_eq("alu_one_rd", {27'd0, rdNum_o}, 32'd5);
        check_eq("alu_one_val", rdVal_o, 32'hDEADBEEF);

        // x0 write is accepted but suppressed; address/data still track the winner
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, ga, gl);
        check_eq("x0_ready", {31'd0, lsuReady_o}, 32'd1);
        idle(ga, gl);
        check_eq("x0_we", {31'd0, regWrite_o}, 32'd0);

        // Sustained contention: L,L,L,A,L,L,L,A
        pat = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 5'd1, 32'hA000 + i, 1'b1, 5'd2, 32'hB000 + i, ga, gl);
            check_eq("starve_grant", {31'd0, aluReady_o}, {31'd0, pat[i]});
            check_eq("starve_flag", {31'd0, aluStarved_o}, {31'd0, pat[i]});
        end
        idle(ga, gl);

        // Same-rd collision: loser (ALU) must land last
        step(1'b0, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, ga, gl);
        step(1'b0, 1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0, ga, gl);
        check_eq("coll_first_val", rdVal_o, 32'd2);
        idle(ga, gl);
        check_eq("coll_second_val", rdVal_o, 32'd1);
        check_eq("coll_second_rd", {27'd0, rdNum_o}, 32'd7);

        // Reset mid-operation with a partially filled starvation count
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, ga, gl);
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, ga, gl);
        step(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, ga, gl);
        pat = 8'b0000_1000;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, ga, gl);
            if (i == 0) check_eq("rst_drop_we", {31'd0, regWrite_o}, 32'd0);
            check_eq("rst_grant", {31'd0, aluReady_o}, {31'd0, pat[i]});
        end
        idle(ga, gl);

        // Random traffic with requests held until accepted
        pa = 1'b0; pl = 1'b0;
        rrd_a = '0; rrd_l = '0; rv_a = '0; rv_l = '0;
        for (int k = 0; k < 60; k++) begin
            if (!pa) begin
                pa = ($urandom_range(0, 3) != 0);
                rrd_a = 5'($urandom_range(0, 31));
                rv_a = $urandom;
            end
            if (!pl) begin
                pl = ($urandom_range(0, 3) != 0);
                rrd_l = 5'($urandom_range(0, 31));
                rv_l = $urandom;
            end
            step(1'b0, pa, rrd_a, rv_a, pl, rrd_l, rv_l, ga, gl);
            if (ga) pa = 1'b0;
            if (gl) pl = 1'b0;
        end
        idle(ga, gl);
        idle(ga, gl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
